chunked_subtractor: RTL and testbench
=====================================

Name: chunked_subtractor

Overview:
- Multi-cycle M-bit subtractor: DIFF = A − B − BIN, computed one N-bit chunk per clock, least-significant chunk first.
- Borrow is registered between chunks.
- Inverse-direction companion to the chained N-bit adder datapath; reuses the same chunk width N so the adder and subtractor benches share stimulus and chunk boundaries.
- Sits in the arithmetic datapath under a START/DONE handshake.

Parameters:
- N, 4, chunk width in bits (≥1)
- K, 2, number of chunks (≥1); operand width M = N*K (localparam, default 8)

Ports:
- CLK  input  1  rising-edge clock
- N_RESET  input  1  asynchronous active-low reset
- START  input  1  request; sampled only while BUSY=0
- A  input  M  minuend, captured on accepted START
- B  input  M  subtrahend, captured on accepted START
- BIN  input  1  borrow-in to chunk 0, captured on accepted START
- BUSY  output  1  high while the operation is in progress (state RUN)
- DONE  output  1  one-cycle pulse: DIFF/BOUT valid and newly updated
- DIFF  output  M  result, held until next completion
- BOUT  output  1  borrow-out of top chunk (1 ⇔ A < B+BIN, unsigned)

Behaviour:
- Reset (N_RESET=0, asynchronous, any state): state=IDLE, BUSY=0, DONE=0, DIFF=0, BOUT=0, chunk index=0, internal operand/borrow registers=0.
  - Reset mid-RUN aborts; no DONE is produced.
  - Reset release takes effect at the next CLK edge.
- States: IDLE, RUN, FIN.
  - IDLE: START=1 at edge → latch A, B, BIN; idx=0; → RUN.
  - RUN: each edge computes {borrow_next, d} = A[idx*N+:N] − B[idx*N+:N] − borrow (N+1-bit arithmetic; borrow_next = MSB of the N+1-bit result). d is written into the accumulator chunk idx, and borrow is registered.
    - idx<K−1: idx++, stay in RUN.
    - idx==K−1: copy accumulator→DIFF, final borrow→BOUT; → FIN.
  - FIN: DONE=1 for exactly this cycle.
    - START=1 at the edge leaving FIN is accepted (back-to-back) → RUN with new operands.
    - Otherwise → IDLE.
- Latency: START sampled at edge t → DONE high in the cycle following edge t+K. Throughput is one operation per K+1 cycles back-to-back.
- BUSY=1 exactly in RUN (K cycles). START while BUSY=1 is ignored; A/B/BIN changes during RUN have no effect.
- DIFF/BOUT change only on the edge entering FIN (and on reset); stable at all other times.
- Wrap-around: DIFF = (A − B − BIN) mod 2^M; BOUT carries the sign of the true result.
- K=1 degenerates to a single RUN cycle; must still work.
- No X propagation: all registers have reset values.

Optional Feature:
- Macro: CHUNKED_SUBTRACTOR_OVF_EN.
- Defined:
  - Adds output OVF (1 bit), reset 0, updated with DIFF on entry to FIN.
  - OVF = 1 when A − B − BIN overflows as two's-complement M-bit: A[M−1]≠B[M−1] and DIFF[M−1]≠A[M−1] (BIN included via the top-chunk borrow). Equivalently, the borrow into the top bit ≠ borrow out of the top bit.
- Undefined: port OVF absent; all other behaviour identical.

Test Plan:
- N=4,K=2: reset, then START with A=0x35, B=0x12, BIN=0 → BUSY high 2 cycles, DONE pulse in cycle after edge t+2, DIFF=0x23, BOUT=0.
- Cross-chunk borrow: A=0x10, B=0x01, BIN=0 → DIFF=0x0F, BOUT=0. Underflow: A=0x00, B=0x01 → DIFF=0xFF, BOUT=1. BIN path: A=0x00, B=0x00, BIN=1 → DIFF=0xFF, BOUT=1.
- START re-asserted with A=0xFF, B=0x00 during BUSY → ignored; first result delivered unchanged, single DONE. Back-to-back START in the FIN cycle → second result exactly 3 cycles later.
- N_RESET pulsed low mid-RUN → BUSY/DONE/DIFF/BOUT go to 0 immediately (asynchronously); no DONE follows. A subsequent START gives the correct result.
- Exhaustive: all A,B ∈ 0..255, BIN ∈ {0,1} → {BOUT,DIFF} == (A − B − BIN) mod 512, and DIFF stable between DONE pulses.
- With CHUNKED_SUBTRACTOR_OVF_EN: A=0x80, B=0x01 → DIFF=0x7F, OVF=1. A=0x7F, B=0xFF → DIFF=0x80, OVF=1. A=0x05, B=0x03 → OVF=0.

Source files
------------

// File: rtl/chunked_subtractor.sv
// chunked_subtractor: multi-cycle (N*K)-bit subtractor DIFF = A - B - BIN, one N-bit chunk per clock, LSB first.
// Define CHUNKED_SUBTRACTOR_OVF_EN to add the two's-complement overflow output OVF.
module chunked_subtractor #(
   parameter int N = 4,
   parameter int K = 2
) (
   input  logic           CLK,
   input  logic           N_RESET,
   input  logic           START,
   input  logic [N*K-1:0] A,
   input  logic [N*K-1:0] B,
   input  logic           BIN,
   output logic           BUSY,
   output logic           DONE,
   output logic [N*K-1:0] DIFF,
   output logic           BOUT
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
   ,
   output logic           OVF
`endif
);
   localparam int M  = N * K;
   localparam int IW = (K > 1) ? $clog2(K) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] idx;
   logic [M-1:0]  a_q;
   logic [M-1:0]  b_q;
   logic [M-1:0]  acc;
   logic          borrow;
   logic [N:0]    res;
   logic [M-1:0]  acc_next;
   logic          last;
   logic          accept;

   function automatic logic [N:0] sub_chunk(input logic [N-1:0] x,
                                            input logic [N-1:0] y,
                                            input logic         bi);
      return {1'b0, x} - {1'b0, y} - {{N{1'b0}}, bi};
   endfunction

   // Operands shift right each RUN cycle so the active chunk always sits at bit 0;
   // the accumulator fills from the top so chunk K-1 lands in the MSBs.
   always_comb begin
      res      = sub_chunk(a_q[N-1:0], b_q[N-1:0], borrow);
      acc_next = (acc >> N) | (M'(res[N-1:0]) << (M - N));
      last     = (idx == IW'(K - 1));
      accept   = START && ((state == IDLE) || (state == FIN));
   end

   assign BUSY = (state == RUN);
   assign DONE = (state == FIN);

   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         state  <= IDLE;
         idx    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         acc    <= '0;
         borrow <= 1'b0;
         DIFF   <= '0;
         BOUT   <= 1'b0;
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
         OVF    <= 1'b0;
`endif
      end else begin
         case (state)
            RUN: begin
               a_q    <= a_q >> N;
               b_q    <= b_q >> N;
               borrow <= res[N];
               acc    <= acc_next;
               if (last) begin
                  DIFF  <= acc_next;
                  BOUT  <= res[N];
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
                  // At the last chunk a_q/b_q bit N-1 hold the original operand sign bits.
                  OVF   <= (a_q[N-1] ^ b_q[N-1]) & (res[N-1] ^ a_q[N-1]);
`endif
                  state <= FIN;
               end else begin
                  idx   <= idx + 1'b1;
               end
            end
            default: begin
               if (accept) begin
                  a_q    <= A;
                  b_q    <= B;
                  borrow <= BIN;
                  acc    <= '0;
                  idx    <= '0;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chunked_subtractor.sv
// Directed bench for chunked_subtractor (N=4, K=2); OVF checks compile in with CHUNKED_SUBTRACTOR_OVF_EN.
module tb_chunked_subtractor;
   logic       CLK = 1'b0;
   logic       N_RESET;
   logic       START;
   logic [7:0] A;
   logic [7:0] B;
   logic       BIN;
   logic       BUSY;
   logic       DONE;
   logic [7:0] DIFF;
   logic       BOUT;
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
   logic       OVF;
`endif

   int         checks = 0;
   int         errors = 0;
   logic [7:0] last_diff = 8'h00;
   logic       last_bout = 1'b0;

   chunked_subtractor #(.N(4), .K(2)) dut (
      .CLK     (CLK),
      .N_RESET (N_RESET),
      .START   (START),
      .A       (A),
      .B       (B),
      .BIN     (BIN),
      .BUSY    (BUSY),
      .DONE    (DONE),
      .DIFF    (DIFF),
      .BOUT    (BOUT)
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
      ,
      .OVF     (OVF)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One full operation from IDLE/FIN: latency, BUSY during RUN, result hold, result.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                         input logic [7:0] ediff, input logic ebout, input string tag);
      int cyc;
      bit stable_bad;
      bit busy_bad;
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
      int r;
`endif
      cyc        = 0;
      stable_bad = 1'b0;
      busy_bad   = 1'b0;
      @(negedge CLK);
      A = a; B = b; BIN = bi; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      while (!DONE && cyc < 8) begin
         if (DIFF !== last_diff || BOUT !== last_bout) stable_bad = 1'b1;
         if (BUSY !== 1'b1) busy_bad = 1'b1;
         @(negedge CLK);
         cyc++;
      end
      chk({tag, " lat"}, cyc, 2);
      chk({tag, " busy"}, {31'd0, busy_bad}, 0);
      chk({tag, " hold"}, {31'd0, stable_bad}, 0);
      chk({tag, " diff"}, {24'd0, DIFF}, {24'd0, ediff});
      chk({tag, " bout"}, {31'd0, BOUT}, {31'd0, ebout});
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
      r = int'($signed(a)) - int'($signed(b)) - int'(bi);
      chk({tag, " ovf"}, {31'd0, OVF}, ((r < -128) || (r > 127)) ? 1 : 0);
`endif
      last_diff = ediff;
      last_bout = ebout;
   endtask

   logic [7:0] bvals [16] = '{8'h00, 8'h01, 8'h0F, 8'h10, 8'h11, 8'h55, 8'h7F, 8'h80,
                              8'h81, 8'hAA, 8'hF0, 8'hFE, 8'hFF, 8'h3C, 8'hC3, 8'h08};

   initial begin
      logic [8:0] e9;
      bit         done_seen;
      N_RESET = 1'b0;
      START   = 1'b0;
      A       = 8'h00;
      B       = 8'h00;
      BIN     = 1'b0;
      #3;
      chk("rst busy", {31'd0, BUSY}, 0);
      chk("rst done", {31'd0, DONE}, 0);
      chk("rst diff", {24'd0, DIFF}, 0);
      chk("rst bout", {31'd0, BOUT}, 0);
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
      chk("rst ovf", {31'd0, OVF}, 0);
`endif
      @(negedge CLK);
      N_RESET = 1'b1;

      run_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, "basic");
      run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, "xborrow");
      run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "under");
      run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "bin");

      // START during BUSY with different operands must be ignored.
      @(negedge CLK);
      A = 8'h35; B = 8'h12; BIN = 1'b0; START = 1'b1;
      @(negedge CLK);
      A = 8'hFF; B = 8'h00; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      chk("ign busy", {31'd0, BUSY}, 1);
      chk("ign nodone", {31'd0, DONE}, 0);
      @(negedge CLK);
      chk("ign done", {31'd0, DONE}, 1);
      chk("ign diff", {24'd0, DIFF}, 32'h23);
      chk("ign bout", {31'd0, BOUT}, 0);
      @(negedge CLK);
      chk("ign single", {31'd0, DONE}, 0);
      chk("ign idle", {31'd0, BUSY}, 0);

      // Back-to-back: second START presented in the FIN cycle.
      A = 8'h10; B = 8'h01; BIN = 1'b0; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      chk("b2b done1", {31'd0, DONE}, 1);
      chk("b2b diff1", {24'd0, DIFF}, 32'h0F);
      A = 8'h00; B = 8'h01; BIN = 1'b0; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      chk("b2b busy", {31'd0, BUSY}, 1);
      chk("b2b gap1", {31'd0, DONE}, 0);
      @(negedge CLK);
      chk("b2b gap2", {31'd0, DONE}, 0);
      @(negedge CLK);
      chk("b2b done2", {31'd0, DONE}, 1);
      chk("b2b diff2", {24'd0, DIFF}, 32'hFF);
      chk("b2b bout2", {31'd0, BOUT}, 1);

      // Asynchronous reset in the middle of RUN.
      @(negedge CLK);
      A = 8'hAA; B = 8'h11; BIN = 1'b0; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      #2;
      N_RESET = 1'b0;
      #1;
      chk("arst busy", {31'd0, BUSY}, 0);
      chk("arst done", {31'd0, DONE}, 0);
      chk("arst diff", {24'd0, DIFF}, 0);
      chk("arst bout", {31'd0, BOUT}, 0);
      @(negedge CLK);
      N_RESET = 1'b1;
      done_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         if (DONE) done_seen = 1'b1;
      end
      chk("arst nodone", {31'd0, done_seen}, 0);
      last_diff = 8'h00;
      last_bout = 1'b0;
      run_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, "post_rst");

`ifdef CHUNKED_SUBTRACTOR_OVF_EN
      run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, "ovf1");
      chk("ovf1 hand", {31'd0, OVF}, 1);
      run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, "ovf2");
      chk("ovf2 hand", {31'd0, OVF}, 1);
      run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "ovf3");
      chk("ovf3 hand", {31'd0, OVF}, 0);
`endif

      // Sweep: every A against a spread of B values, both borrow-in values.
      for (int bi = 0; bi < 2; bi++) begin
         for (int j = 0; j < 16; j++) begin
            for (int a = 0; a < 256; a++) begin
               e9 = {1'b0, 8'(a)} - {1'b0, bvals[j]} - {8'd0, 1'(bi)};
               run_op(8'(a), bvals[j], 1'(bi), e9[7:0], e9[8], "sweep");
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
